// File: rtl/sargantana_icache_refill.sv
// rtl/sargantana_icache_refill.sv - icache line refill engine: one burst read per line fill.
// Optional ICACHE_REFILL_ERR_EN adds the sticky err_o read-burst protocol check.
module sargantana_icache_refill #(
  parameter int LINE_ADDR_W = 36,
  parameter int LINE_W      = 128,
  parameter int BEAT_W      = 64,
  parameter int WAY_W       = 2
) (
  input  logic                   clk_i,
  input  logic                   rstn_i,
  input  logic                   flush_i,
  input  logic                   kill_i,
  input  logic                   req_valid_i,
  input  logic [LINE_ADDR_W-1:0] req_paddr_i,
  input  logic [WAY_W-1:0]       req_way_i,
  output logic                   busy_o,
  output logic                   bus_ar_valid_o,
  input  logic                   bus_ar_ready_i,
  output logic [LINE_ADDR_W-1:0] bus_ar_addr_o,
  input  logic                   bus_r_valid_i,
  input  logic [BEAT_W-1:0]      bus_r_data_i,
  input  logic                   bus_r_last_i,
  output logic                   bus_r_ready_o,
  output logic                   resp_valid_o,
  output logic [LINE_W-1:0]      resp_data_o,
  output logic [WAY_W-1:0]       resp_way_o,
  output logic [LINE_ADDR_W-1:0] resp_paddr_o
`ifdef ICACHE_REFILL_ERR_EN
  ,
  output logic                   err_o
`endif
);

  localparam int NBEATS = LINE_W / BEAT_W;
  localparam int CNT_W  = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NBEATS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t                  state_q;
  logic [CNT_W-1:0]        beat_cnt_q;
  logic                    kill_pend_q;
  logic [LINE_ADDR_W-1:0]  paddr_q;
  logic [WAY_W-1:0]        way_q;
  logic [LINE_W-1:0]       line_q;

  logic beat_fire;
  logic beat_is_last;
  logic err_evt;
  logic abort;

  assign beat_fire    = (state_q == DATA) && bus_r_valid_i;
  assign beat_is_last = (beat_cnt_q == LAST_CNT);

`ifdef ICACHE_REFILL_ERR_EN
  // r_last must coincide exactly with the final counted beat; stray beats are also errors
  assign err_evt = (beat_fire && (bus_r_last_i != beat_is_last)) ||
                   (bus_r_valid_i && (state_q != DATA));

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      err_o <= 1'b0;
    end else if (err_evt) begin
      err_o <= 1'b1;
    end
  end
`else
  logic unused_r_last;
  assign unused_r_last = bus_r_last_i;
  assign err_evt       = 1'b0;
`endif

  assign abort = kill_i || flush_i || err_evt;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q     <= IDLE;
      beat_cnt_q  <= '0;
      kill_pend_q <= 1'b0;
      paddr_q     <= '0;
      way_q       <= '0;
      line_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          kill_pend_q <= 1'b0;
          if (req_valid_i && !abort) begin
            paddr_q    <= req_paddr_i;
            way_q      <= req_way_i;
            beat_cnt_q <= '0;
            line_q     <= '0;
            state_q    <= ADDR;
          end
        end
        ADDR: begin
          // once the address handshake happens the burst must be drained, even if killed
          if (bus_ar_ready_i) begin
            state_q <= DATA;
            if (abort) begin
              kill_pend_q <= 1'b1;
            end
          end else if (abort) begin
            state_q <= IDLE;
          end
        end
        DATA: begin
          if (abort) begin
            kill_pend_q <= 1'b1;
          end
          if (beat_fire) begin
            for (int b = 0; b < NBEATS; b++) begin
              if (beat_cnt_q == CNT_W'(b)) begin
                line_q[b*BEAT_W +: BEAT_W] <= bus_r_data_i;
              end
            end
            beat_cnt_q <= beat_cnt_q + 1'b1;
            if (beat_is_last) begin
              state_q <= (kill_pend_q || abort) ? IDLE : RESP;
            end
          end
        end
        RESP: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy_o         = (state_q != IDLE);
  assign bus_ar_valid_o = (state_q == ADDR);
  assign bus_ar_addr_o  = paddr_q;
  assign bus_r_ready_o  = (state_q == DATA);
  assign resp_valid_o   = (state_q == RESP) && !abort;
  assign resp_data_o    = line_q;
  assign resp_way_o     = way_q;
  assign resp_paddr_o   = paddr_q;

endmodule

// File: tb/tb_sargantana_icache_refill.sv
// tb/tb_sargantana_icache_refill.sv - table-driven bench for sargantana_icache_refill.
module tb_sargantana_icache_refill;

  logic         clk;
  logic         rstn;
  logic         flush, kill, req_valid;
  logic [35:0]  req_paddr;
  logic [1:0]   req_way;
  logic         busy, ar_valid, ar_ready;
  logic [35:0]  ar_addr;
  logic         r_valid, r_last, r_ready;
  logic [63:0]  r_data;
  logic         resp_valid;
  logic [127:0] resp_data;
  logic [1:0]   resp_way;
  logic [35:0]  resp_paddr;
`ifdef ICACHE_REFILL_ERR_EN
  logic         err;
`endif

  sargantana_icache_refill dut (
    .clk_i          (clk),
    .rstn_i         (rstn),
    .flush_i        (flush),
    .kill_i         (kill),
    .req_valid_i    (req_valid),
    .req_paddr_i    (req_paddr),
    .req_way_i      (req_way),
    .busy_o         (busy),
    .bus_ar_valid_o (ar_valid),
    .bus_ar_ready_i (ar_ready),
    .bus_ar_addr_o  (ar_addr),
    .bus_r_valid_i  (r_valid),
    .bus_r_data_i   (r_data),
    .bus_r_last_i   (r_last),
    .bus_r_ready_o  (r_ready),
    .resp_valid_o   (resp_valid),
    .resp_data_o    (resp_data),
    .resp_way_o     (resp_way),
    .resp_paddr_o   (resp_paddr)
`ifdef ICACHE_REFILL_ERR_EN
    ,
    .err_o          (err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         req;
    logic [35:0]  paddr;
    logic [1:0]   way;
    logic         kill, flush, arr, rv;
    logic [63:0]  rd;
    logic         rl;
    logic         ebusy, earv, errdy, eresp, chk;
    logic [127:0] edata;
    logic [1:0]   eway;
    logic [35:0]  epaddr;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;
  int   hs_cnt = 0;

  always @(negedge clk) if (ar_valid && ar_ready) hs_cnt++;

  function automatic void add(logic req, logic [35:0] paddr, logic [1:0] way, logic k, logic f,
                              logic arr, logic rv, logic [63:0] rd, logic rl,
                              logic ebusy, logic earv, logic errdy, logic eresp, logic chk,
                              logic [127:0] edata, logic [1:0] eway, logic [35:0] epaddr);
    vec_t v;
    v.req = req; v.paddr = paddr; v.way = way; v.kill = k; v.flush = f;
    v.arr = arr; v.rv = rv; v.rd = rd; v.rl = rl;
    v.ebusy = ebusy; v.earv = earv; v.errdy = errdy; v.eresp = eresp; v.chk = chk;
    v.edata = edata; v.eway = eway; v.epaddr = epaddr;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic req, input logic [35:0] paddr, input logic [1:0] way,
                       input logic k, input logic f, input logic arr, input logic rv,
                       input logic [63:0] rd, input logic rl);
    @(posedge clk);
    #1;
    req_valid = req; req_paddr = paddr; req_way = way; kill = k; flush = f;
    ar_ready = arr; r_valid = rv; r_data = rd; r_last = rl;
  endtask

  localparam logic [63:0] D0 = 64'hAAAA_0000_1111_2222;
  localparam logic [63:0] D1 = 64'hBBBB_3333_4444_5555;
  localparam logic [63:0] E0 = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] E1 = 64'hFEDC_BA98_7654_3210;

  initial begin
    int hs_base;
    rstn = 1'b0;
    req_valid = 0; req_paddr = '0; req_way = '0; kill = 0; flush = 0;
    ar_ready = 0; r_valid = 0; r_data = '0; r_last = 0;

    // basic fill
    add(1, 36'h1234, 2, 0,0, 0, 0, 0, 0,   0,0,0,0, 0, 0, 0, 0);
    add(0, 0, 0,        0,0, 1, 0, 0, 0,   1,1,0,0, 0, 0, 0, 36'h1234);
    add(0, 0, 0,        0,0, 0, 1, D0, 0,  1,0,1,0, 0, 0, 0, 0);
    add(0, 0, 0,        0,0, 0, 1, D1, 1,  1,0,1,0, 0, 0, 0, 0);
    add(0, 0, 0,        0,0, 0, 0, 0, 0,   1,0,0,1, 1, {D1, D0}, 2, 36'h1234);
    add(0, 0, 0,        0,0, 0, 0, 0, 0,   0,0,0,0, 1, {D1, D0}, 2, 36'h1234);
    // address backpressure
    add(1, 36'hABCDE, 1, 0,0, 0, 0, 0, 0,  0,0,0,0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++)
      add(0, 0, 0,      0,0, 0, 0, 0, 0,   1,1,0,0, 0, 0, 0, 36'hABCDE);
    add(0, 0, 0,        0,0, 1, 0, 0, 0,   1,1,0,0, 0, 0, 0, 36'hABCDE);
    add(0, 0, 0,        0,0, 0, 1, E0, 0,  1,0,1,0, 0, 0, 0, 0);
    add(0, 0, 0,        0,0, 0, 1, E1, 1,  1,0,1,0, 0, 0, 0, 0);
    add(0, 0, 0,        0,0, 0, 0, 0, 0,   1,0,0,1, 1, {E1, E0}, 1, 36'hABCDE);
    add(0, 0, 0,        0,0, 0, 0, 0, 0,   0,0,0,0, 0, 0, 0, 0);
    // kill in ADDR before handshake
    add(1, 36'h777, 3,  0,0, 0, 0, 0, 0,   0,0,0,0, 0, 0, 0, 0);
    add(0, 0, 0,        1,0, 0, 0, 0, 0,   1,1,0,0, 0, 0, 0, 36'h777);
    add(0, 0, 0,        0,0, 1, 0, 0, 0,   0,0,0,0, 0, 0, 0, 0);
    add(0, 0, 0,        0,0, 0, 0, 0, 0,   0,0,0,0, 0, 0, 0, 0);
    // flush in DATA, burst drained, then a clean refill
    add(1, 36'h999, 0,  0,0, 0, 0, 0, 0,   0,0,0,0, 0, 0, 0, 0);
    add(0, 0, 0,        0,0, 1, 0, 0, 0,   1,1,0,0, 0, 0, 0, 36'h999);
    add(0, 0, 0,        0,0, 0, 1, 64'h1111, 0, 1,0,1,0, 0, 0, 0, 0);
    add(0, 0, 0,        0,1, 0, 0, 0, 0,   1,0,1,0, 0, 0, 0, 0);
    add(0, 0, 0,        0,0, 0, 1, 64'h2222, 1, 1,0,1,0, 0, 0, 0, 0);
    add(1, 36'h55, 1,   0,0, 0, 0, 0, 0,   0,0,0,0, 0, 0, 0, 0);
    add(0, 0, 0,        0,0, 1, 0, 0, 0,   1,1,0,0, 0, 0, 0, 36'h55);
    add(0, 0, 0,        0,0, 0, 1, 64'h5, 0, 1,0,1,0, 0, 0, 0, 0);
    add(0, 0, 0,        0,0, 0, 1, 64'h6, 1, 1,0,1,0, 0, 0, 0, 0);
    add(0, 0, 0,        0,0, 0, 0, 0, 0,   1,0,0,1, 1, {64'h6, 64'h5}, 1, 36'h55);
    add(0, 0, 0,        0,0, 0, 0, 0, 0,   0,0,0,0, 0, 0, 0, 0);
    // kill in RESP suppresses the strobe
    add(1, 36'h66, 2,   0,0, 0, 0, 0, 0,   0,0,0,0, 0, 0, 0, 0);
    add(0, 0, 0,        0,0, 1, 0, 0, 0,   1,1,0,0, 0, 0, 0, 36'h66);
    add(0, 0, 0,        0,0, 0, 1, 64'h7, 0, 1,0,1,0, 0, 0, 0, 0);
    add(0, 0, 0,        0,0, 0, 1, 64'h8, 1, 1,0,1,0, 0, 0, 0, 0);
    add(0, 0, 0,        1,0, 0, 0, 0, 0,   1,0,0,0, 1, {64'h8, 64'h7}, 2, 36'h66);
    add(0, 0, 0,        0,0, 0, 0, 0, 0,   0,0,0,0, 0, 0, 0, 0);
    // kill in the handshake cycle: burst issued and drained, no response
    add(1, 36'h88, 0,   0,0, 0, 0, 0, 0,   0,0,0,0, 0, 0, 0, 0);
    add(0, 0, 0,        1,0, 1, 0, 0, 0,   1,1,0,0, 0, 0, 0, 36'h88);
    add(0, 0, 0,        0,0, 0, 1, 64'h9, 0, 1,0,1,0, 0, 0, 0, 0);
    add(0, 0, 0,        0,0, 0, 1, 64'hA, 1, 1,0,1,0, 0, 0, 0, 0);
    add(0, 0, 0,        0,0, 0, 0, 0, 0,   0,0,0,0, 0, 0, 0, 0);
    // request coincident with kill / flush is not accepted
    add(1, 36'hDEAD, 1, 1,0, 0, 0, 0, 0,   0,0,0,0, 0, 0, 0, 0);
    add(1, 36'hBEEF, 2, 0,1, 0, 0, 0, 0,   0,0,0,0, 0, 0, 0, 0);
    add(0, 0, 0,        0,0, 0, 0, 0, 0,   0,0,0,0, 0, 0, 0, 0);

    // reset state
    @(negedge clk);
    check("rst busy", busy, 0);
    check("rst ar_valid", ar_valid, 0);
    check("rst r_ready", r_ready, 0);
    check("rst resp_valid", resp_valid, 0);
    check("rst resp_data", resp_data, 0);
    check("rst ar_addr", ar_addr, 0);
`ifdef ICACHE_REFILL_ERR_EN
    check("rst err", err, 0);
`endif
    @(negedge clk);
    rstn = 1'b1;

    foreach (vecs[i]) begin
      drive(vecs[i].req, vecs[i].paddr, vecs[i].way, vecs[i].kill, vecs[i].flush,
            vecs[i].arr, vecs[i].rv, vecs[i].rd, vecs[i].rl);
      @(negedge clk);
      check($sformatf("row%0d busy", i), busy, vecs[i].ebusy);
      check($sformatf("row%0d ar_valid", i), ar_valid, vecs[i].earv);
      check($sformatf("row%0d r_ready", i), r_ready, vecs[i].errdy);
      check($sformatf("row%0d resp_valid", i), resp_valid, vecs[i].eresp);
      if (vecs[i].earv) check($sformatf("row%0d ar_addr", i), ar_addr, vecs[i].epaddr);
      if (vecs[i].chk) begin
        check($sformatf("row%0d resp_data", i), resp_data, vecs[i].edata);
        check($sformatf("row%0d resp_way", i), resp_way, vecs[i].eway);
        check($sformatf("row%0d resp_paddr", i), resp_paddr, vecs[i].epaddr);
      end
    end

    // request while busy is ignored, then reset mid-DATA
    hs_base = hs_cnt;
    drive(1, 36'h300, 1, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      drive(1, 36'h400, 3, 0, 0, 1, 0, 0, 0);
      @(negedge clk);
      check("busy req ignored busy", busy, 1);
      check("busy req ignored ar_valid", ar_valid, 0);
      check("busy req ignored r_ready", r_ready, 1);
    end
    drive(0, 0, 0, 0, 0, 0, 1, 64'hCAFE, 0);
    @(negedge clk);
    check("single ar handshake", hs_cnt - hs_base, 1);
    check("paddr kept", resp_paddr, 36'h300);
    req_valid = 0; r_valid = 0; r_data = '0;
    rstn = 1'b0;
    #1;
    check("midrst busy", busy, 0);
    check("midrst r_ready", r_ready, 0);
    check("midrst ar_valid", ar_valid, 0);
    check("midrst resp_valid", resp_valid, 0);
    check("midrst resp_data", resp_data, 0);
    check("midrst resp_way", resp_way, 0);
    check("midrst resp_paddr", resp_paddr, 0);
    @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      check("postrst resp_valid", resp_valid, 0);
      check("postrst busy", busy, 0);
    end

    // r_last asserted on the first beat
    drive(1, 36'hE0, 1, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 1, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 1, 64'h11, 1);
    drive(0, 0, 0, 0, 0, 0, 1, 64'h22, 1);
    @(negedge clk);
`ifdef ICACHE_REFILL_ERR_EN
    check("early last err", err, 1);
`endif
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
`ifdef ICACHE_REFILL_ERR_EN
    check("early last no resp", resp_valid, 0);
    check("early last idle", busy, 0);
    check("early last err sticky", err, 1);
`else
    check("early last resp", resp_valid, 1);
    check("early last data", resp_data, {64'h22, 64'h11});
    check("early last way", resp_way, 1);
`endif
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check("early last after resp", resp_valid, 0);
`ifdef ICACHE_REFILL_ERR_EN
    check("err still sticky", err, 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sargantana_icache_refill.md
Name: sargantana_icache_refill

Overview:
- Refill engine directly upstream of the instruction cache fill port.
- Accepts one line-fill request (line paddr + victim way) from the icache, issues a single burst read on the L2 read bus, and assembles NBEATS data beats into one cache line.
- Returns the line in a single-cycle fill response with data, way and paddr.
- Drops the response if the fetch is killed or flushed mid-flight; the burst is still drained to keep the bus coherent.

Parameters:
- LINE_ADDR_W, 36, width of line address (tag + set index, no offset)
- LINE_W, 128, cache-line width in bits
- BEAT_W, 64, bus read-data width; LINE_W must be an integer multiple; NBEATS = LINE_W/BEAT_W
- WAY_W, 2, victim way index width

Ports:
- clk_i  in  1  clock
- rstn_i  in  1  asynchronous active-low reset
- flush_i  in  1  icache flush; same effect as kill on the in-flight refill
- kill_i  in  1  fetch kill for the in-flight refill
- req_valid_i  in  1  fill request strobe
- req_paddr_i  in  LINE_ADDR_W  line address to fetch
- req_way_i  in  WAY_W  way to be filled
- busy_o  out  1  engine not IDLE; requests are ignored while high
- bus_ar_valid_o  out  1  read-address valid
- bus_ar_ready_i  in  1  read-address ready
- bus_ar_addr_o  out  LINE_ADDR_W  latched line address
- bus_r_valid_i  in  1  read-data beat valid
- bus_r_data_i  in  BEAT_W  read-data beat
- bus_r_last_i  in  1  final beat of burst
- bus_r_ready_o  out  1  high in DATA state
- resp_valid_o  out  1  one-cycle fill response strobe
- resp_data_o  out  LINE_W  assembled line
- resp_way_o  out  WAY_W  latched way
- resp_paddr_o  out  LINE_ADDR_W  latched line address

Behaviour:
- Reset (async, rstn_i low): state=IDLE, beat_cnt=0, kill_pend=0.
- Reset values: all valid/ready/busy outputs 0, data/addr/way registers 0.
- Reset mid-burst abandons the burst; no response follows.
- FSM states: IDLE, ADDR, DATA, RESP.
- IDLE:
  - On req_valid_i, latch paddr and way, clear beat_cnt and line buffer, go to ADDR.
  - req_valid_i together with kill_i or flush_i in the same cycle: request not accepted.
- ADDR:
  - bus_ar_valid_o=1, addr held stable until handshake (ar_valid & ar_ready), then go to DATA.
  - kill_i or flush_i before the handshake: go to IDLE, no bus transaction.
  - kill_i or flush_i in the handshake cycle itself: transaction is issued, kill_pend=1, go to DATA.
- DATA:
  - bus_r_ready_o=1.
  - Each accepted beat is written to line[beat_cnt*BEAT_W +: BEAT_W]; beat 0 occupies the LSBs. beat_cnt then increments (width clog2(NBEATS), NBEATS=1 handled).
  - kill_i or flush_i at any time in DATA sets kill_pend (sticky until IDLE).
  - Completion is the beat with beat_cnt==NBEATS-1. bus_r_last_i is ignored for control (see optional feature).
  - On completion: go to RESP if kill_pend==0, else go to IDLE silently.
- RESP:
  - resp_valid_o=1 for exactly one cycle with stable data/way/paddr, then go to IDLE.
  - kill_i or flush_i in RESP: resp_valid_o is suppressed that cycle, go to IDLE.
- Latency, no kill and ar_ready=1 immediately: request at cycle 0, ar_valid at cycle 1, beats from cycle 2, resp_valid one cycle after the last beat.
- busy_o = (state != IDLE); it is registered-state-derived.
- Back-to-back: a new request is accepted only in IDLE, the cycle after RESP at the earliest.
- resp_data_o holds its value after RESP until the next accepted request.

Optional Feature:
- ICACHE_REFILL_ERR_EN
- Defined:
  - Adds output err_o (1 bit, reset 0), a sticky protocol error cleared only by reset.
  - Set when bus_r_last_i=1 on a beat with beat_cnt != NBEATS-1, or when bus_r_last_i=0 on the beat with beat_cnt == NBEATS-1.
  - Set when bus_r_valid_i=1 outside DATA.
  - The refill in progress on error is treated as killed: no response.
- Undefined: port absent, r_last ignored, behaviour as above.

Test Plan:
- Basic fill: req paddr=0x1234, way=2, ar_ready=1, beats 0xAAAA_0000_1111_2222 then 0xBBBB_3333_4444_5555 (last on 2nd) -> resp_valid one pulse 1 cycle after beat 2, resp_data=0xBBBB333344445555_AAAA000011112222, resp_way=2, resp_paddr=0x1234.
- Address backpressure: ar_ready low 5 cycles -> ar_valid stays 1 with addr stable; DATA entered the cycle after ready; response correct.
- Kill in ADDR: kill_i 1 cycle before ar_ready -> no ar handshake, busy_o low next cycle, no resp.
- Kill in DATA: flush_i after beat 0 -> beat 1 still accepted (r_ready=1), no resp_valid, busy_o low after beat 1; a new request 0x55 then completes normally.
- Ignored request + reset: req_valid_i pulsed while busy -> ignored, no second ar; rstn_i asserted mid-DATA -> all outputs 0 immediately, state IDLE.
- ICACHE_REFILL_ERR_EN build: r_last on beat 0 -> err_o=1 sticky, no resp; with macro off, same stimulus -> normal resp after beat 1.
